// File: rtl/datapath_ctrl.sv
// Multi-cycle control FSM for the single-datapath core: fetch/decode/exec/mem/wb sequencing,
// data-memory wait handshake and sticky illegal-opcode trap. Optional perf counters: DPCTRL_PERF_EN.
module datapath_ctrl #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic [4:0]  status,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pcsrc,
  output logic        alusrc,
  output logic [3:0]  aluop,
  output logic        memrw,
  output logic        wb,
  output logic        regrw,
  output logic [1:0]  immgen_ctrl,
  output logic        trap,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_NONE   = 3'd0,
    K_R      = 3'd1,
    K_I      = 3'd2,
    K_LOAD   = 3'd3,
    K_STORE  = 3'd4,
    K_BRANCH = 3'd5
  } kind_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_XOR = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_SL  = 4'b0101;
  localparam logic [3:0] ALU_SR  = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b0111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Returns {legal, aluop} for R/I-ALU funct3; NOR only exists in the R encoding.
  function automatic logic [4:0] alu_decode(input logic [2:0] f3, input logic is_r, input logic alt);
    logic [4:0] res;
    res = 5'b0_0000;
    case (f3)
      3'b000:  res = {1'b1, ALU_ADD};
      3'b100:  res = {1'b1, ALU_XOR};
      3'b111:  res = {1'b1, ALU_AND};
      3'b110:  res = (is_r && alt) ? {1'b1, ALU_NOR} : {1'b1, ALU_OR};
      3'b001:  res = {1'b1, ALU_SL};
      3'b101:  res = {1'b1, ALU_SR};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  function automatic logic br_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b101: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Signed less-than from the SUB flags is neg XOR ovf.
  function automatic logic br_taken(input logic [2:0] f3, input logic [4:0] st);
    logic tk;
    case (f3)
      3'b000:  tk = st[0];
      3'b001:  tk = ~st[0];
      3'b100:  tk = st[1] ^ st[3];
      3'b101:  tk = ~(st[1] ^ st[3]);
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  state_t      state_r, state_s;
  kind_t       kind_r, dec_kind_s;
  logic [2:0]  funct3_r;
  logic [3:0]  aluop_r, dec_aluop_s;
  logic        alusrc_r, dec_alusrc_s;
  logic [1:0]  imm_r, dec_imm_s;
  logic        wb_r;
  logic        dec_legal_s;
  logic [4:0]  alu_res_s;
  logic        ir_we_s, pc_we_s, pcsrc_s, memrw_s, regrw_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{instr[31], instr[29:15], instr[11:7], status[4], status[2]};

  // Instruction decode of the IR word presented by the datapath.
  always_comb begin
    dec_kind_s   = K_NONE;
    dec_aluop_s  = ALU_ADD;
    dec_alusrc_s = 1'b0;
    dec_imm_s    = IMM_I;
    dec_legal_s  = 1'b0;
    alu_res_s    = alu_decode(instr[14:12], (instr[6:0] == OP_R), instr[30]);
    case (instr[6:0])
      OP_R: begin
        dec_kind_s  = K_R;
        dec_aluop_s = alu_res_s[3:0];
        dec_legal_s = alu_res_s[4];
      end
      OP_I: begin
        dec_kind_s   = K_I;
        dec_aluop_s  = alu_res_s[3:0];
        dec_alusrc_s = 1'b1;
        dec_legal_s  = alu_res_s[4];
      end
      OP_LOAD: begin
        dec_kind_s   = K_LOAD;
        dec_alusrc_s = 1'b1;
        dec_legal_s  = 1'b1;
      end
      OP_STORE: begin
        dec_kind_s   = K_STORE;
        dec_alusrc_s = 1'b1;
        dec_imm_s    = IMM_S;
        dec_legal_s  = 1'b1;
      end
      OP_BRANCH: begin
        dec_kind_s  = K_BRANCH;
        dec_aluop_s = ALU_SUB;
        dec_imm_s   = IMM_B;
        dec_legal_s = br_legal(instr[14:12]);
      end
      default: begin
        dec_kind_s  = K_NONE;
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Next-state and per-phase strobe generation.
  always_comb begin
    state_s = state_r;
    ir_we_s = 1'b0;
    pc_we_s = 1'b0;
    pcsrc_s = 1'b0;
    memrw_s = 1'b0;
    regrw_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (run) begin
          ir_we_s = 1'b1;
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_legal_s) begin
          state_s = S_EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          state_s = S_TRAP;
        end else begin
          pc_we_s = 1'b1;
          state_s = S_FETCH;
        end
      end
      S_EXEC: begin
        case (kind_r)
          K_R, K_I:         state_s = S_WB;
          K_LOAD, K_STORE:  state_s = S_MEM;
          K_BRANCH: begin
            pc_we_s = 1'b1;
            pcsrc_s = br_taken(funct3_r, status);
            state_s = S_FETCH;
          end
          default:          state_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        // A store's completing cycle carries both the write and the PC update.
        memrw_s = (kind_r == K_STORE);
        if (!mem_ready) begin
          state_s = S_MEM;
        end else if (kind_r == K_STORE) begin
          pc_we_s = 1'b1;
          state_s = S_FETCH;
        end else begin
          state_s = S_WB;
        end
      end
      S_WB: begin
        regrw_s = 1'b1;
        pc_we_s = 1'b1;
        state_s = S_FETCH;
      end
      S_TRAP: begin
        state_s = S_TRAP;
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Decode registers: captured in DECODE, held until the next DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_r   <= K_NONE;
      funct3_r <= 3'b000;
      aluop_r  <= 4'b0000;
      alusrc_r <= 1'b0;
      imm_r    <= 2'b00;
      wb_r     <= 1'b0;
    end else if (state_r == S_DECODE) begin
      if (dec_legal_s) begin
        kind_r   <= dec_kind_s;
        funct3_r <= instr[14:12];
        aluop_r  <= dec_aluop_s;
        alusrc_r <= dec_alusrc_s;
        imm_r    <= dec_imm_s;
        wb_r     <= (dec_kind_s == K_LOAD);
      end else begin
        kind_r   <= K_NONE;
        funct3_r <= 3'b000;
        aluop_r  <= 4'b0000;
        alusrc_r <= 1'b0;
        imm_r    <= 2'b00;
        wb_r     <= 1'b0;
      end
    end else begin
      kind_r   <= kind_r;
      funct3_r <= funct3_r;
      aluop_r  <= aluop_r;
      alusrc_r <= alusrc_r;
      imm_r    <= imm_r;
      wb_r     <= wb_r;
    end
  end

  // Strobes are masked by reset so an asserted rst kills them in the same cycle.
  assign ir_we       = ir_we_s & rst;
  assign pc_we       = pc_we_s & rst;
  assign pcsrc       = pcsrc_s & rst;
  assign memrw       = memrw_s & rst;
  assign regrw       = regrw_s & rst;
  assign trap        = (state_r == S_TRAP);
  assign aluop       = aluop_r;
  assign alusrc      = alusrc_r;
  assign immgen_ctrl = imm_r;
  assign wb          = wb_r;

`ifdef DPCTRL_PERF_EN
  logic [31:0] cycle_cnt_r;
  logic [31:0] instret_cnt_r;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_r   <= 32'd0;
      instret_cnt_r <= 32'd0;
    end else begin
      if (state_r != S_TRAP) begin
        cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (pc_we_s) begin
        instret_cnt_r <= instret_cnt_r + 32'd1;
      end else begin
        instret_cnt_r <= instret_cnt_r;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
